// File: rtl/pixel_framebuffer.sv
// Canvas RAM with a brush-stamp/clear write engine and a bordered raster read port.
// Latency: read data registered one cycle after rx/ry; writes land one pixel per cycle after acceptance.
// Backpressure: cmd_ready only while idle; commands offered while busy are not taken.
module pixel_framebuffer #(
   parameter int            AW           = 7,
   parameter int            CW           = 3,
   parameter int            RW           = 10,
   parameter int            BW           = 3,
   parameter logic [CW-1:0] BORDER_COLOR = 3'd1,
   parameter logic [CW-1:0] CLEAR_COLOR  = 3'd0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_clear,
   input  logic [AW-1:0] cmd_x,
   input  logic [AW-1:0] cmd_y,
   input  logic [BW-1:0] cmd_size,
   input  logic [CW-1:0] cmd_color,
   input  logic [RW-1:0] rx,
   input  logic [RW-1:0] ry,
   output logic [CW-1:0] color_code,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_STAMP, S_CLEAR} state_t;

   localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

   state_t          r_state, w_state_nxt;
   // Counters carry one extra bit so stepping past the canvas edge is visible.
   logic [AW:0]     r_cx, r_cy, w_cx_nxt, w_cy_nxt;
   logic [AW:0]     w_x_inc, w_y_inc;
   logic [AW:0]     r_x0, r_xend, r_yend;
   logic [CW-1:0]   r_color;
   logic [BW-1:0]   w_n;
   logic            w_accept;
   logic            w_we;
   logic [2*AW-1:0] w_waddr;
   logic [CW-1:0]   w_wdat;
   logic [CW-1:0]   r_mem [0:(2**(2*AW))-1];

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_n       = (cmd_size == '0) ? BW'(1) : cmd_size;
   assign w_x_inc   = r_cx + ONE;
   assign w_y_inc   = r_cy + ONE;

   // Next-state, counter stepping and write-port drive for the engine.
   always_comb begin
      w_state_nxt = r_state;
      w_cx_nxt    = r_cx;
      w_cy_nxt    = r_cy;
      w_we        = 1'b0;
      w_wdat      = r_color;
      w_waddr     = {r_cy[AW-1:0], r_cx[AW-1:0]};
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = cmd_clear ? S_CLEAR : S_STAMP;
               w_cx_nxt    = cmd_clear ? '0 : {1'b0, cmd_x};
               w_cy_nxt    = cmd_clear ? '0 : {1'b0, cmd_y};
            end
         end
         S_STAMP: begin
            // Current pixel is always on-canvas; a clipped column ends the row,
            // a clipped row ends the stamp.
            w_we = 1'b1;
            if (w_x_inc < r_xend && !w_x_inc[AW]) begin
               w_cx_nxt = w_x_inc;
            end else if (w_y_inc < r_yend && !w_y_inc[AW]) begin
               w_cx_nxt = r_x0;
               w_cy_nxt = w_y_inc;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CLEAR: begin
            w_we   = 1'b1;
            w_wdat = CLEAR_COLOR;
            if (r_cx == LAST) begin
               w_cx_nxt = '0;
               if (r_cy == LAST) w_state_nxt = S_IDLE;
               else              w_cy_nxt    = w_y_inc;
            end else begin
               w_cx_nxt = w_x_inc;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Engine state and pixel counters; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cx    <= '0;
         r_cy    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cx    <= w_cx_nxt;
         r_cy    <= w_cy_nxt;
      end
   end

   // Latch stamp geometry and colour at acceptance so the source may move on.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_x0    <= '0;
         r_xend  <= '0;
         r_yend  <= '0;
         r_color <= '0;
      end else if (w_accept) begin
         r_x0    <= {1'b0, cmd_x};
         r_xend  <= {1'b0, cmd_x} + {{(AW+1-BW){1'b0}}, w_n};
         r_yend  <= {1'b0, cmd_y} + {{(AW+1-BW){1'b0}}, w_n};
         r_color <= cmd_color;
      end
   end

   // Canvas write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdat;
   end

   // Registered raster read; off-canvas coordinates return the border colour.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         color_code <= '0;
      end else if ((|rx[RW-1:AW]) || (|ry[RW-1:AW])) begin
         color_code <= BORDER_COLOR;
      end else begin
         color_code <= r_mem[{ry[AW-1:0], rx[AW-1:0]}];
      end
   end

endmodule
